serial_diff_unit: RTL and testbench
===================================

Name: serial_diff_unit

Overview:
- Multi-cycle, digit-serial add/subtract unit. It is the parametrised successor of the 6-bit ripple full-difference chain.
- Operands are captured on a start handshake. DIGIT bits are processed per cycle through a registered borrow/carry, so one narrow digit slice is reused across a WIDTH-bit word.
- It returns a (WIDTH+1)-bit result whose MSB is the final borrow (subtract) or carry (add), plus zero and signed-overflow flags.
- It sits in the ALU datapath wherever area matters more than latency.

Parameters:
- WIDTH, 6: operand width in bits. Must be ≥2.
- DIGIT, 1: bits processed per RUN cycle. Must divide WIDTH; compile-time error otherwise.

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted on a rising edge when busy=0
- mode  input  1  0 = subtract (x - y), 1 = add (x + y); sampled with start
- x  input  WIDTH  minuend/addend A; sampled with start
- y  input  WIDTH  subtrahend/addend B; sampled with start
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse: result and flags valid
- result  output  WIDTH+1  [WIDTH-1:0] = sum/difference mod 2^WIDTH; [WIDTH] = carry (add) or borrow (sub)
- zero  output  1  result[WIDTH-1:0] == 0
- overflow  output  1  two's-complement overflow of the WIDTH-bit result

Behaviour:
- Interface: one clock; reset is synchronous and active-high. On a reset edge: state=IDLE; busy=0, done=0, result=0, zero=0, overflow=0; internal count, borrow/carry and operand registers are cleared. Reset wins over any simultaneous start.
- Derived constant N = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch x, y and mode; clear count; set digit borrow/carry-in to 0.
  - Go to RUN with busy=1.
- RUN:
  - Each cycle, process bit slice [count*DIGIT +: DIGIT] with the registered borrow/carry.
  - Subtract: diff_i = a_i ^ b_i ^ bin; bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
  - Add: standard full-adder.
  - Write the slice into the result register; increment count.
  - After the N-th RUN cycle, go to DONE, busy=0.
  - start is ignored while busy=1; no queuing.
- DONE:
  - done=1 for exactly this one cycle.
  - result[WIDTH] = final borrow/carry.
  - zero and overflow are valid.
  - Overflow rule, subtract: x[W-1] != y[W-1] and result[W-1] != x[W-1].
  - Overflow rule, add: x[W-1] == y[W-1] and result[W-1] != x[W-1].
  - If start=1 in this cycle, it is accepted (back-to-back): go to RUN. Otherwise go to IDLE.
- Latency:
  - start sampled at edge 0 → busy high for N cycles → done high in the cycle after edge N.
  - Throughput: one operation per N+1 cycles.
- Output holding:
  - result, zero and overflow hold their last values until the next accepted start. At that start they are cleared to 0, and result fills digit by digit.
  - The bench must sample them only when done=1 or afterwards in IDLE.
- Operand isolation: changes on x, y or mode after acceptance have no effect on the running operation.
- Reset mid-RUN: the operation is aborted and no done pulse is produced. The next start after reset behaves normally.
- Wrap-around:
  - Subtract with x<y (unsigned) gives result[WIDTH]=1 and low bits = (x-y+2^WIDTH).
  - Add overflow beyond 2^WIDTH sets result[WIDTH]=1.

Test Plan:
- WIDTH=6, DIGIT=1, sub, x=45, y=12 → busy for 6 cycles; then done=1, result=7'b0100001 (33), zero=0, overflow=0.
- WIDTH=6, DIGIT=1, sub, x=12, y=45 → result=7'b1011111 (borrow=1, low=31); overflow=0. Then sub x=32, y=1 → low=31, borrow=0, overflow=1.
- WIDTH=6, DIGIT=1, sub x=63, y=63 → result=0, zero=1. Then add x=63, y=1 → result=7'b1000000, zero=1, overflow=0.
- WIDTH=6, DIGIT=3, add x=20, y=25 → busy exactly 2 cycles, done in cycle 3, result=45. Then start held high through done → second operation accepted back-to-back, done every 3 cycles.
- Start pulsed again at RUN cycle 2 with different x/y → ignored: original result returned, done pulses once. Operand inputs toggled during RUN → no effect.
- Reset asserted at RUN cycle 3 together with start=1 → next cycle busy=0, done=0, result=0; no done pulse follows. A fresh start then completes with correct result.

Source files
------------

// File: rtl/serial_diff_unit.sv
// Digit-serial add/subtract unit: DIGIT bits per cycle through a registered
// borrow/carry, returning a (WIDTH+1)-bit result plus zero and overflow flags.
module serial_diff_unit #(
  parameter int WIDTH = 6,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             zero,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_badParams
      $error("serial_diff_unit: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             xSign_q, xSign_d;
  logic             ySign_q, ySign_d;
  logic [WIDTH-1:0] resLow_q, resLow_d;
  logic             resMsb_q, resMsb_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] sliceOut;
  logic             sliceCarry;
  logic [WIDTH-1:0] shiftedRes;

  // Operands shift right each cycle, so the low DIGIT bits are always the live slice.
  always_comb begin
    logic c;
    c = carry_q;
    sliceOut = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sliceOut[i] = a_q[i] ^ b_q[i] ^ c;
      if (mode_q) begin
        c = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
      end else begin
        c = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c);
      end
    end
    sliceCarry = c;
  end

  // New slice enters at the top; after N cycles digit 0 has reached bit 0.
  assign shiftedRes = (resLow_q >> DIGIT) | (WIDTH'(sliceOut) << (WIDTH - DIGIT));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    xSign_d  = xSign_q;
    ySign_d  = ySign_q;
    resLow_d = resLow_q;
    resMsb_d = resMsb_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (state_q)
      RUN: begin
        carry_d  = sliceCarry;
        resLow_d = shiftedRes;
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        if (count_q == LAST) begin
          state_d  = DONE;
          resMsb_d = sliceCarry;
          zero_d   = (shiftedRes == '0);
          if (mode_q) begin
            ovf_d = (xSign_q == ySign_q) && (shiftedRes[WIDTH-1] != xSign_q);
          end else begin
            ovf_d = (xSign_q != ySign_q) && (shiftedRes[WIDTH-1] != xSign_q);
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Acceptance from IDLE or back-to-back from DONE; ignored while running.
    if ((state_q != RUN) && start) begin
      state_d  = RUN;
      count_d  = '0;
      carry_d  = 1'b0;
      mode_d   = mode;
      a_d      = x;
      b_d      = y;
      xSign_d  = x[WIDTH-1];
      ySign_d  = y[WIDTH-1];
      resLow_d = '0;
      resMsb_d = 1'b0;
      zero_d   = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      xSign_q  <= 1'b0;
      ySign_q  <= 1'b0;
      resLow_q <= '0;
      resMsb_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      xSign_q  <= xSign_d;
      ySign_q  <= ySign_d;
      resLow_q <= resLow_d;
      resMsb_q <= resMsb_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = {resMsb_q, resLow_q};
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_diff_unit.sv
// Directed bench for serial_diff_unit: a DIGIT=1 instance and a DIGIT=3 instance,
// both WIDTH=6, sharing clock and reset.
module tb_serial_diff_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       start1, mode1, busy1, done1, zero1, ovf1;
  logic [5:0] x1, y1;
  logic [6:0] result1;
  logic       start3, mode3, busy3, done3, zero3, ovf3;
  logic [5:0] x3, y3;
  logic [6:0] result3;

  int errors = 0;
  int checks = 0;
  int busyCnt;
  int doneCnt;
  bit seen;

  serial_diff_unit #(.WIDTH(6), .DIGIT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .mode(mode1), .x(x1), .y(y1),
    .busy(busy1), .done(done1), .result(result1), .zero(zero1), .overflow(ovf1)
  );

  serial_diff_unit #(.WIDTH(6), .DIGIT(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .mode(mode3), .x(x3), .y(y3),
    .busy(busy3), .done(done3), .result(result3), .zero(zero3), .overflow(ovf3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Leaves the bench at the negedge of the first RUN cycle.
  task automatic applyStimulus(input logic m, input logic [5:0] a, input logic [5:0] b);
    @(negedge clock);
    start1 = 1'b1; mode1 = m; x1 = a; y1 = b;
    @(negedge clock);
    start1 = 1'b0;
  endtask

  // Bounded wait for done on dut1, counting busy cycles on the way.
  task automatic waitDone(output int bc, output bit sn);
    bc = 0;
    sn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done1) begin
        sn = 1'b1;
        break;
      end
      if (busy1) bc++;
      @(negedge clock);
    end
  endtask

  task automatic checkResult(input string tag, input logic [6:0] r, input logic z, input logic o);
    checkOutput({tag, "_result"}, result1, r);
    checkOutput({tag, "_zero"}, zero1, z);
    checkOutput({tag, "_overflow"}, ovf1, o);
  endtask

  task automatic runOp(input string tag, input logic m, input logic [5:0] a, input logic [5:0] b,
                       input logic [6:0] r, input logic z, input logic o);
    applyStimulus(m, a, b);
    waitDone(busyCnt, seen);
    checkOutput({tag, "_doneSeen"}, seen, 1);
    checkOutput({tag, "_busyCycles"}, busyCnt, 6);
    checkResult(tag, r, z, o);
    @(negedge clock);
    checkOutput({tag, "_donePulse"}, done1, 0);
    checkOutput({tag, "_idle"}, busy1, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start1 = 1'b0; mode1 = 1'b0; x1 = '0; y1 = '0;
    start3 = 1'b0; mode3 = 1'b0; x3 = '0; y3 = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_done", done1, 0);
    checkOutput("rst_result", result1, 0);
    checkOutput("rst_zero", zero1, 0);
    checkOutput("rst_ovf", ovf1, 0);
    checkOutput("rst_busy3", busy3, 0);
    checkOutput("rst_result3", result3, 0);
    reset = 1'b0;

    runOp("sub45_12", 1'b0, 6'd45, 6'd12, 7'd33, 1'b0, 1'b0);
    runOp("sub12_45", 1'b0, 6'd12, 6'd45, 7'd95, 1'b0, 1'b0);
    runOp("sub32_1",  1'b0, 6'd32, 6'd1,  7'd31, 1'b0, 1'b1);
    runOp("sub63_63", 1'b0, 6'd63, 6'd63, 7'd0,  1'b1, 1'b0);
    runOp("add63_1",  1'b1, 6'd63, 6'd1,  7'd64, 1'b1, 1'b0);
    runOp("add31_1",  1'b1, 6'd31, 6'd1,  7'd32, 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    checkResult("holdIdle", 7'd32, 1'b0, 1'b1);

    // Restart and operand changes during RUN must not disturb 20-5.
    applyStimulus(1'b0, 6'd20, 6'd5);
    @(negedge clock);
    start1 = 1'b1; mode1 = 1'b1; x1 = 6'd60; y1 = 6'd3;
    @(negedge clock);
    start1 = 1'b0; x1 = 6'd63; y1 = 6'd63;
    waitDone(busyCnt, seen);
    checkOutput("ignore_doneSeen", seen, 1);
    checkOutput("ignore_busyCycles", busyCnt, 4);
    checkResult("ignore", 7'd15, 1'b0, 1'b0);
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done1) doneCnt++;
    end
    checkOutput("ignore_extraDone", doneCnt, 0);
    checkOutput("ignore_idle", busy1, 0);

    // DIGIT=3: two busy cycles, start held high gives back-to-back operations.
    @(negedge clock);
    start3 = 1'b1; mode3 = 1'b1; x3 = 6'd20; y3 = 6'd25;
    @(negedge clock);
    checkOutput("d3_busy1", busy3, 1);
    x3 = 6'd10; y3 = 6'd7;
    @(negedge clock);
    checkOutput("d3_busy2", busy3, 1);
    checkOutput("d3_notDoneYet", done3, 0);
    @(negedge clock);
    checkOutput("d3_done", done3, 1);
    checkOutput("d3_busyLow", busy3, 0);
    checkOutput("d3_result", result3, 45);
    checkOutput("d3_zero", zero3, 0);
    checkOutput("d3_ovf", ovf3, 1);
    @(negedge clock);
    checkOutput("b2b_doneLow", done3, 0);
    checkOutput("b2b_busy1", busy3, 1);
    @(negedge clock);
    checkOutput("b2b_busy2", busy3, 1);
    @(negedge clock);
    checkOutput("b2b_done", done3, 1);
    checkOutput("b2b_result", result3, 17);
    checkOutput("b2b_ovf", ovf3, 0);
    start3 = 1'b0;
    @(negedge clock);
    checkOutput("b2b_idleDone", done3, 0);
    checkOutput("b2b_idleBusy", busy3, 0);
    checkOutput("b2b_hold", result3, 17);

    // Reset in the third RUN cycle, together with start, aborts the operation.
    applyStimulus(1'b0, 6'd50, 6'd10);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; start1 = 1'b1; x1 = 6'd5; y1 = 6'd2;
    @(negedge clock);
    reset = 1'b0; start1 = 1'b0;
    checkOutput("abort_busy", busy1, 0);
    checkOutput("abort_done", done1, 0);
    checkOutput("abort_result", result1, 0);
    checkOutput("abort_zero", zero1, 0);
    checkOutput("abort_ovf", ovf1, 0);
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done1) doneCnt++;
    end
    checkOutput("abort_noDone", doneCnt, 0);
    runOp("afterReset", 1'b1, 6'd7, 6'd8, 7'd15, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
